issue_window_scheduler: RTL and testbench

//  Issue-stage scheduler between dependence check and the LSU/CSR/ALU issue units. Captures one 16-slot bundle
//  (73-bit entries, slot 0 oldest) via drive/free handshake and trims slots younger than the first branch.

---
 rtl/issue_window_scheduler.sv | 155 +++++++++++++++
 tb/tb_issue_window_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_window_scheduler.sv
// rtl/issue_window_scheduler.sv - 16-slot issue window dispatching to LSU, CSR and ALU ports
module issue_window_scheduler (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_DriveFromDecode_1,
    output logic          o_FreeToDecode_1,
    input  logic [1167:0] i_Bundle_1168,
    input  logic [15:0]   i_ValidMask_16,
    input  logic          i_HasBranch_1,
    input  logic [3:0]    i_FirstBranchIndex_4,
    input  logic          i_Flush_1,
    output logic          o_DriveToLsu_1,
    input  logic          i_FreeFromLsu_1,
    output logic [72:0]   o_InstToLsu_73,
    output logic [3:0]    o_SlotToLsu_4,
    output logic          o_DriveToCsr_1,
    input  logic          i_FreeFromCsr_1,
    output logic [72:0]   o_InstToCsr_73,
    output logic [3:0]    o_SlotToCsr_4,
    output logic          o_DriveToAlu_1,
    input  logic          i_FreeFromAlu_1,
    output logic [72:0]   o_InstToAlu_73,
    output logic [3:0]    o_SlotToAlu_4,
    output logic [15:0]   o_Pending_16
);

    localparam int SLOTS  = 16;
    localparam int INST_W = 73;

    typedef enum logic {IDLE, ISSUE} stateT;

    stateT              state;
    stateT              stateNext;
    logic [15:0]        pending;
    logic [15:0]        pendingNext;
    logic [15:0]        isLsu;
    logic [15:0]        isCsr;
    logic [INST_W-1:0]  entries [SLOTS];

    logic [15:0]        capLsu;
    logic [15:0]        capCsr;
    logic [15:0]        keep;
    logic [15:0]        capPending;
    logic               capture;

    logic [4:0]         barrier;
    logic [15:0]        belowBarrier;
    logic [4:0]         lsuIdx;
    logic [4:0]         aluIdx;
    logic               csrReady;
    logic               inIssue;
    logic               lsuXfer;
    logic               csrXfer;
    logic               aluXfer;
    logic [15:0]        issued;
    logic [15:0]        remaining;

    // Lowest set bit index; 16 when the vector is empty
    function automatic logic [4:0] lowestSet(input logic [15:0] v);
        lowestSet = 5'd16;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (v[k]) lowestSet = 5'(k);
        end
    endfunction

    // Decode incoming bundle: opcode class per slot and branch trimming
    always_comb begin
        capLsu = '0;
        capCsr = '0;
        keep   = '0;
        for (int k = 0; k < SLOTS; k++) begin
            capLsu[k] = (i_Bundle_1168[INST_W*k +: 7] == 7'b0000011) ||
                        (i_Bundle_1168[INST_W*k +: 7] == 7'b0100011) ||
                        (i_Bundle_1168[INST_W*k +: 7] == 7'b0101111);
            capCsr[k] = (i_Bundle_1168[INST_W*k +: 7] == 7'b1110011);
            keep[k]   = !i_HasBranch_1 || (4'(k) <= i_FirstBranchIndex_4);
        end
        capPending = i_ValidMask_16 & keep;
    end

    // Candidate selection: CSR slots split the window; nothing younger than a CSR issues before it
    always_comb begin
        barrier      = lowestSet(pending & isCsr);
        belowBarrier = '0;
        for (int k = 0; k < SLOTS; k++) begin
            belowBarrier[k] = (5'(k) < barrier);
        end
        lsuIdx   = lowestSet(pending & isLsu & belowBarrier);
        aluIdx   = lowestSet(pending & ~isLsu & ~isCsr & belowBarrier);
        csrReady = !barrier[4] && ((pending & belowBarrier) == 16'd0);
    end

    // Port outputs are pure muxes of registered state
    always_comb begin
        inIssue          = (state == ISSUE);
        o_FreeToDecode_1 = (state == IDLE) && !i_Flush_1 && !rst;
        o_Pending_16     = pending;
        o_DriveToLsu_1   = inIssue && !lsuIdx[4];
        o_SlotToLsu_4    = lsuIdx[3:0];
        o_InstToLsu_73   = entries[lsuIdx[3:0]];
        o_DriveToAlu_1   = inIssue && !aluIdx[4];
        o_SlotToAlu_4    = aluIdx[3:0];
        o_InstToAlu_73   = entries[aluIdx[3:0]];
        o_DriveToCsr_1   = inIssue && csrReady;
        o_SlotToCsr_4    = barrier[3:0];
        o_InstToCsr_73   = entries[barrier[3:0]];
    end

    // Transfers, next pending set and next state
    always_comb begin
        capture   = (state == IDLE) && i_DriveFromDecode_1 && o_FreeToDecode_1;
        lsuXfer   = o_DriveToLsu_1 && i_FreeFromLsu_1;
        csrXfer   = o_DriveToCsr_1 && i_FreeFromCsr_1;
        aluXfer   = o_DriveToAlu_1 && i_FreeFromAlu_1;
        issued    = (16'(lsuXfer) << o_SlotToLsu_4) |
                    (16'(csrXfer) << o_SlotToCsr_4) |
                    (16'(aluXfer) << o_SlotToAlu_4);
        remaining = pending & ~issued;
        stateNext = state;
        if (i_Flush_1) begin
            pendingNext = '0;
            stateNext   = IDLE;
        end else if (capture) begin
            pendingNext = capPending;
            if (capPending != 16'd0) stateNext = ISSUE;
        end else begin
            pendingNext = remaining;
            if (state == ISSUE && remaining == 16'd0) stateNext = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Pending register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pendingNext;
    end

    // Entry and class storage; only meaningful where pending is set, so never reset
    always_ff @(posedge clk) begin
        if (capture) begin
            isLsu <= capLsu;
            isCsr <= capCsr;
            for (int k = 0; k < SLOTS; k++) begin
                entries[k] <= i_Bundle_1168[INST_W*k +: INST_W];
            end
        end
    end

endmodule

// File: tb/tb_issue_window_scheduler.sv
// tb/tb_issue_window_scheduler.sv - bench for issue_window_scheduler
module tb_issue_window_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic          driveDec;
    logic          freeDec;
    logic [1167:0] bundle;
    logic [15:0]   mask;
    logic          hasBr;
    logic [3:0]    fbi;
    logic          flush;
    logic          drvL, drvC, drvA;
    logic          frL, frC, frA;
    logic [72:0]   instL, instC, instA;
    logic [3:0]    slotL, slotC, slotA;
    logic [15:0]   pend;

    int total = 0;
    int bad   = 0;

    // Reference model: which slots remain, what they hold, and their class (0 ALU, 1 LSU, 2 CSR)
    logic [72:0] mEnt [16];
    int          mCls [16];
    logic [15:0] mPend;
    bit          mIssue;
    int          eL, eC, eA;
    bit          eDrvL, eDrvC, eDrvA, eFree;

    always #5 clk = ~clk;

    issue_window_scheduler dut (
        .clk(clk), .rst(rst),
        .i_DriveFromDecode_1(driveDec), .o_FreeToDecode_1(freeDec),
        .i_Bundle_1168(bundle), .i_ValidMask_16(mask),
        .i_HasBranch_1(hasBr), .i_FirstBranchIndex_4(fbi), .i_Flush_1(flush),
        .o_DriveToLsu_1(drvL), .i_FreeFromLsu_1(frL), .o_InstToLsu_73(instL), .o_SlotToLsu_4(slotL),
        .o_DriveToCsr_1(drvC), .i_FreeFromCsr_1(frC), .o_InstToCsr_73(instC), .o_SlotToCsr_4(slotC),
        .o_DriveToAlu_1(drvA), .i_FreeFromAlu_1(frA), .o_InstToAlu_73(instA), .o_SlotToAlu_4(slotA),
        .o_Pending_16(pend)
    );

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int classOf(input logic [6:0] op);
        if (op == 7'h03 || op == 7'h23 || op == 7'h2F) return 1;
        if (op == 7'h73) return 2;
        return 0;
    endfunction

    // Directed bundles; unused slots get non-memory opcodes and all slots carry random payload
    task automatic loadBundle(input int sel);
        logic [6:0] ops [16];
        for (int k = 0; k < 16; k++) ops[k] = 7'h33;
        hasBr = 1'b0;
        fbi   = 4'd0;
        mask  = 16'h0000;
        case (sel)
            1: begin ops[1] = 7'h03; ops[2] = 7'h13; ops[3] = 7'h23; mask = 16'h000F; end
            2: begin ops[1] = 7'h73; ops[2] = 7'h03; mask = 16'h0007; end
            3: begin mask = 16'hFFFF; hasBr = 1'b1; fbi = 4'd2; end
            4: begin ops[1] = 7'h03; ops[4] = 7'h03; mask = 16'h001F; end
            default: mask = 16'h0000;
        endcase
        for (int k = 0; k < 16; k++)
            bundle[73*k +: 73] = {2'($urandom()), $urandom(), $urandom(), ops[k]};
    endtask

    task automatic randomBundle();
        logic [6:0] pick [7];
        pick = '{7'h03, 7'h23, 7'h2F, 7'h73, 7'h33, 7'h13, 7'h63};
        for (int k = 0; k < 16; k++)
            bundle[73*k +: 73] = {2'($urandom()), $urandom(), $urandom(), pick[$urandom_range(0, 6)]};
        mask  = 16'($urandom());
        hasBr = 1'($urandom_range(0, 1));
        fbi   = 4'($urandom());
    endtask

    // Compare DUT outputs against the model for the current input values
    task automatic sample();
        int  b;
        #1;
        if (rst) begin
            mIssue = 0;
            mPend  = '0;
        end
        b  = 16;
        eL = -1;
        eA = -1;
        eC = -1;
        for (int k = 0; k < 16; k++)
            if (b == 16 && mPend[k] && mCls[k] == 2) b = k;
        for (int k = 0; k < b; k++) begin
            if (mPend[k] && mCls[k] == 1 && eL < 0) eL = k;
            if (mPend[k] && mCls[k] == 0 && eA < 0) eA = k;
        end
        if (b < 16 && eL < 0 && eA < 0) eC = b;
        eDrvL = mIssue && eL >= 0;
        eDrvA = mIssue && eA >= 0;
        eDrvC = mIssue && eC >= 0;
        eFree = !mIssue && !flush && !rst;
        check("free", 73'(freeDec), 73'(eFree));
        check("pending", 73'(pend), 73'(mPend));
        check("lsu.drive", 73'(drvL), 73'(eDrvL));
        check("csr.drive", 73'(drvC), 73'(eDrvC));
        check("alu.drive", 73'(drvA), 73'(eDrvA));
        if (eDrvL) begin
            check("lsu.slot", 73'(slotL), 73'(eL));
            check("lsu.inst", instL, mEnt[eL]);
        end
        if (eDrvC) begin
            check("csr.slot", 73'(slotC), 73'(eC));
            check("csr.inst", instC, mEnt[eC]);
        end
        if (eDrvA) begin
            check("alu.slot", 73'(slotA), 73'(eA));
            check("alu.inst", instA, mEnt[eA]);
        end
    endtask

    // Clock edge: update the model with this cycle's inputs, return at the next falling edge
    task automatic advance();
        bit capt;
        capt = !mIssue && driveDec && eFree;
        @(posedge clk);
        if (rst) begin
            mIssue = 0;
            mPend  = '0;
        end else if (flush) begin
            mIssue = 0;
            mPend  = '0;
        end else if (capt) begin
            for (int k = 0; k < 16; k++) begin
                mEnt[k]  = bundle[73*k +: 73];
                mCls[k]  = classOf(bundle[73*k +: 7]);
                mPend[k] = mask[k] && (!hasBr || k <= int'(fbi));
            end
            mIssue = (mPend != 16'd0);
        end else begin
            if (eDrvL && frL) mPend[eL] = 1'b0;
            if (eDrvC && frC) mPend[eC] = 1'b0;
            if (eDrvA && frA) mPend[eA] = 1'b0;
            if (mPend == 16'd0) mIssue = 0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        int          bsel;
        logic [2:0]  frees;
        logic [2:0]  drv;
        logic [3:0]  sL;
        logic [3:0]  sC;
        logic [3:0]  sA;
        logic        free;
        logic [15:0] pend;
    } vecT;

    vecT         vecs [14];
    logic [72:0] heldInst;

    initial begin
        // frees/drv bit order: {lsu, csr, alu}
        vecs[0]  = '{1, 3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000};
        vecs[1]  = '{0, 3'b111, 3'b101, 4'd1, 4'd0, 4'd0, 1'b0, 16'h000F};
        vecs[2]  = '{0, 3'b111, 3'b101, 4'd3, 4'd0, 4'd2, 1'b0, 16'h000C};
        vecs[3]  = '{0, 3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000};
        vecs[4]  = '{2, 3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000};
        vecs[5]  = '{0, 3'b111, 3'b001, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0007};
        vecs[6]  = '{0, 3'b111, 3'b010, 4'd0, 4'd1, 4'd0, 1'b0, 16'h0006};
        vecs[7]  = '{0, 3'b111, 3'b100, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0004};
        vecs[8]  = '{0, 3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000};
        vecs[9]  = '{3, 3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000};
        vecs[10] = '{0, 3'b111, 3'b001, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0007};
        vecs[11] = '{0, 3'b111, 3'b001, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0006};
        vecs[12] = '{0, 3'b111, 3'b001, 4'd0, 4'd0, 4'd2, 1'b0, 16'h0004};
        vecs[13] = '{0, 3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000};

        rst = 1'b1; driveDec = 1'b0; bundle = '0; mask = '0; hasBr = 1'b0; fbi = '0;
        flush = 1'b0; frL = 1'b0; frC = 1'b0; frA = 1'b0;
        mPend = '0; mIssue = 0;
        for (int k = 0; k < 16; k++) begin mEnt[k] = '0; mCls[k] = 0; end
        @(negedge clk);
        sample();
        check("reset.free", 73'(freeDec), 73'(1'b0));
        advance();
        rst = 1'b0;

        // Directed table: plain issue, CSR barrier, branch trimming
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].bsel != 0) begin loadBundle(vecs[i].bsel); driveDec = 1'b1; end
            else driveDec = 1'b0;
            {frL, frC, frA} = vecs[i].frees;
            sample();
            check($sformatf("vec%0d.drv", i), 73'({drvL, drvC, drvA}), 73'(vecs[i].drv));
            if (vecs[i].drv[2]) check($sformatf("vec%0d.slotL", i), 73'(slotL), 73'(vecs[i].sL));
            if (vecs[i].drv[1]) check($sformatf("vec%0d.slotC", i), 73'(slotC), 73'(vecs[i].sC));
            if (vecs[i].drv[0]) check($sformatf("vec%0d.slotA", i), 73'(slotA), 73'(vecs[i].sA));
            check($sformatf("vec%0d.free", i), 73'(freeDec), 73'(vecs[i].free));
            check($sformatf("vec%0d.pend", i), 73'(pend), 73'(vecs[i].pend));
            advance();
        end

        // LSU stalled on slot 1 while ALU drains slots 0, 2, 3
        loadBundle(4); driveDec = 1'b1; {frL, frC, frA} = 3'b111;
        sample(); advance();
        driveDec = 1'b0; frL = 1'b0;
        sample();
        heldInst = instL;
        advance();
        for (int c = 1; c < 5; c++) begin
            sample();
            check("hold.drive", 73'(drvL), 73'(1'b1));
            check("hold.slot", 73'(slotL), 73'(4'd1));
            check("hold.inst", instL, heldInst);
            advance();
        end
        check("hold.pend", 73'(pend), 73'(16'h0012));
        frL = 1'b1;
        sample(); advance();
        sample();
        check("hold.release", 73'(pend), 73'(16'h0010));
        advance();
        sample(); advance();

        // Flush after first issue with a new bundle offered in the flush cycle
        loadBundle(1); driveDec = 1'b1;
        sample(); advance();
        driveDec = 1'b0;
        sample(); advance();
        flush = 1'b1; loadBundle(2); driveDec = 1'b1;
        sample();
        check("flush.free", 73'(freeDec), 73'(1'b0));
        advance();
        flush = 1'b0; driveDec = 1'b0;
        sample();
        check("flush.pend", 73'(pend), 73'(16'h0000));
        check("flush.drives", 73'({drvL, drvC, drvA}), 73'(3'b000));
        check("flush.freeAfter", 73'(freeDec), 73'(1'b1));
        advance();

        // Empty mask capture, then asynchronous reset while ports are driving
        loadBundle(5); driveDec = 1'b1;
        sample(); advance();
        driveDec = 1'b0;
        sample();
        check("empty.pend", 73'(pend), 73'(16'h0000));
        check("empty.free", 73'(freeDec), 73'(1'b1));
        advance();
        loadBundle(1); driveDec = 1'b1; {frL, frC, frA} = 3'b000;
        sample(); advance();
        driveDec = 1'b0;
        sample();
        check("prerst.drives", 73'({drvL, drvA}), 73'(2'b11));
        rst = 1'b1;
        sample();
        check("rst.drives", 73'({drvL, drvC, drvA}), 73'(3'b000));
        check("rst.free", 73'(freeDec), 73'(1'b0));
        check("rst.pend", 73'(pend), 73'(16'h0000));
        advance();
        rst = 1'b0;
        sample();
        check("rst.release", 73'(freeDec), 73'(1'b1));
        advance();

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 31) == 0);
            frL = ($urandom_range(0, 3) != 0);
            frC = ($urandom_range(0, 3) != 0);
            frA = ($urandom_range(0, 3) != 0);
            driveDec = 1'($urandom_range(0, 1));
            if (driveDec) randomBundle();
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
